// File: rtl/ones_window_counter_pkg.sv
// Shared types and constants for the windowed ones counter feeding the 3-bit rounder.
package ones_window_counter_pkg;

    localparam int unsigned CNT_W      = 3;
    localparam int unsigned WINDOW_MAX = 7;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic bit window_legal(input int unsigned w);
        return (w >= 1) && (w <= WINDOW_MAX);
    endfunction

endpackage

// File: rtl/ones_window_counter_if.sv
// Sample-in / count-out handshake bundle for ones_window_counter.
interface ones_window_counter_if;
    import ones_window_counter_pkg::*;

    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_valid;
    logic             cnt_ready;

    // master: the surrounding sample source and count sink
    modport master (
        output bit_in, bit_valid, cnt_ready,
        input  bit_ready, cnt_out, cnt_valid
    );

    modport slave (
        input  bit_in, bit_valid, cnt_ready,
        output bit_ready, cnt_out, cnt_valid
    );

endinterface

// File: rtl/ones_window_counter.sv
// Counts ones over WINDOW accepted serial samples and presents the 3-bit count
// under valid/ready backpressure.
module ones_window_counter
    import ones_window_counter_pkg::*;
#(
    parameter int unsigned WINDOW = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    ones_window_counter_if.slave bus
);

    if (!window_legal(WINDOW)) begin : g_window_check
        $error("ones_window_counter: WINDOW=%0d outside 1..%0d", WINDOW, WINDOW_MAX);
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] acc_plus;
    logic             accept;
    logic             xfer;
    logic             last;

    // bit_ready depends only on state and cnt_ready, never on bit_valid
    assign bus.bit_ready = (state_q == ACCUM) ? 1'b1 : bus.cnt_ready;
    assign bus.cnt_out   = cnt_q;
    assign bus.cnt_valid = valid_q;

    assign accept   = bus.bit_valid & bus.bit_ready;
    assign xfer     = valid_q & bus.cnt_ready;
    assign last     = (idx_q == LAST_IDX);
    assign acc_plus = acc_q + CNT_W'(bus.bit_in);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (last) begin
                        cnt_d   = acc_plus;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = HOLD;
                    end else begin
                        acc_d = acc_plus;
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // In HOLD an accept implies a transfer, so a completing sample
                // reloads the count in place and the pending flag stays set.
                if (xfer) begin
                    if (accept && last) begin
                        cnt_d = acc_plus;
                        acc_d = '0;
                        idx_d = '0;
                    end else begin
                        if (accept) begin
                            acc_d = acc_plus;
                            idx_d = idx_q + CNT_W'(1);
                        end
                        valid_d = 1'b0;
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: doc/ones_window_counter.md
Name: ones_window_counter

Overview:
- Upstream feeder for the 3-bit rounder stage.
- Consumes a serial 1-bit sample stream under a valid/ready handshake and counts the ones over a fixed window of WINDOW accepted samples.
- Presents the 3-bit count (0..7) as a registered word with valid/ready backpressure; the rounder's a2/a1/a0 inputs connect directly to cnt_out[2:0].

Parameters:
- WINDOW, 7, number of accepted samples per count; legal range 1..7, so the count always fits in 3 bits.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- bit_in  input  1  sample value
- bit_valid  input  1  sample present this cycle
- bit_ready  output  1  block can accept a sample this cycle
- cnt_out  output  3  ones count of the last completed window; MSB-first maps to a2,a1,a0
- cnt_valid  output  1  cnt_out holds an unconsumed count
- cnt_ready  input  1  downstream accepts cnt_out this cycle

Behaviour:
- Reset: rst sampled high on a rising clk edge. Next cycle state=ACCUM, acc=0, idx=0, cnt_out=3'b000, cnt_valid=0. A partial window or pending count is discarded. rst has priority over all other inputs.
- Sample accept: occurs when bit_valid & bit_ready. Input bits not accepted are ignored.
- Output handshake: a transfer occurs when cnt_valid & cnt_ready.
- States: ACCUM (collecting samples, no pending output) and HOLD (count pending).
- ACCUM:
  - bit_ready=1.
  - On accept with idx<WINDOW-1: acc<=acc+bit_in, idx<=idx+1.
  - On accept with idx==WINDOW-1: cnt_out<=acc+bit_in, cnt_valid<=1, acc<=0, idx<=0, go HOLD.
- HOLD:
  - bit_ready=cnt_ready (combinational path, which allows zero-bubble streaming).
  - cnt_out and cnt_valid are held stable until transfer.
  - Transfer with no accept: cnt_valid<=0, go ACCUM.
  - Transfer plus accept that does not complete a window: acc/idx update as in ACCUM, cnt_valid<=0, go ACCUM.
  - Transfer plus accept that completes a window (only possible for WINDOW=1): cnt_out<=bit_in, cnt_valid stays 1, stay HOLD.
- Latency: cnt_valid rises on the cycle after the WINDOW-th sample is accepted.
- Throughput: one sample per cycle while downstream keeps cnt_ready=1.
- Width: acc is 3 bits with no saturation logic, since the maximum is WINDOW≤7. An all-ones window with WINDOW=7 gives 3'b111.
- Idle gaps (bit_valid=0) do not advance idx. A window spans any number of cycles.
- cnt_ready while cnt_valid=0 has no effect.
- Outputs are registered except bit_ready, which is a function of state and cnt_ready only and never depends on bit_valid.

Decomposition:
- Shared package:
  - state encoding constants ACCUM=1'b0, HOLD=1'b1
  - CNT_W=3
  - WINDOW_MAX=7
  - an elaboration check that WINDOW is in 1..WINDOW_MAX
- Sub-module: none. The index counter and accumulator are small enough to stay inline; a separate window_idx_ctr module is not justified.

Test Plan:
- Reset mid-window, WINDOW=7: feed 1,1,1, assert rst one cycle, then feed seven 0s -> cnt_out=0, cnt_valid=1 once, on the cycle after the 7th sample.
- Pattern 1,0,1,1,0,1,1 with cnt_ready=1 -> cnt_out=3'b101 (5), cnt_valid high exactly one cycle, bit_ready never low.
- Seven 1s then hold cnt_ready=0 for 4 cycles with bit_valid=1 -> cnt_out=3'b111 stable, bit_ready=0, no samples counted. On cnt_ready=1 the next window starts with the sample presented that cycle.
- Gappy input: seven 1-samples interleaved with bit_valid=0 bubbles -> count 7, idx unaffected by bubbles.
- WINDOW=1, cnt_ready=1, stream 1,0,1 back-to-back -> cnt_valid stays 1 and cnt_out goes 1,0,1 on consecutive cycles, with no bubble.
- WINDOW=3, stream 1,1,0 | 0,0,1 -> counts 2 then 1, matching the rounder inputs 3'b010 and 3'b001.
